if_fetch_stage: RTL and testbench
=================================

Name: if_fetch_stage

Overview:
Instruction-fetch stage and IF/ID pipeline register. It is the consumer of the EX stage's next-PC/redirect output. It holds the architectural PC and fetches from instruction memory over a req/rvalid handshake with one request outstanding. It presents instruction, PC and PC+4 to ID, with stall from the hazard unit and flush on EX redirect.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
NOP_INSTR, 32'h0000_0013, value driven on instr_id_o when the slot is invalid (addi x0,x0,0)

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  synchronous active-low reset
jump_taken_if_i  in  1  EX redirect valid (taken branch, jal or jalr), single-cycle pulse
pc_new_if_i  in  32  redirect target from EX
stall_if_i  in  1  hazard-unit stall; ID cannot accept a new instruction
imem_req_o  out  1  fetch request, 1-cycle pulse
imem_addr_o  out  32  fetch address, valid while imem_req_o=1
imem_rdata_i  in  32  fetched instruction, valid with imem_rvalid_i
imem_rvalid_i  in  1  response strobe, arrives ≥1 cycle after the req
instr_id_o  out  32  IF/ID instruction
pc_id_o  out  32  IF/ID instruction address
pc_order_id_o  out  32  IF/ID pc+4
valid_id_o  out  1  IF/ID slot holds a real instruction
pc_if_o  out  32  current fetch PC

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - pc<=RESET_PC, state<=ISSUE, imem_req_o=0.
  - valid_id_o=0, instr_id_o=NOP_INSTR, pc_id_o=0, pc_order_id_o=0, hold register cleared.
  - Any outstanding response is ignored while in reset.
  - First request goes out in the first cycle with rst_n=1.
- Redirect targets: pc_new_if_i[1:0] forced to 2'b00 when loaded into pc.
- One outstanding request max. imem_rvalid_i outside WAIT/KILL is ignored.
- FSM:
  - ISSUE: imem_req_o=1, imem_addr_o=pc. Next state WAIT. If jump_taken_if_i in the same cycle: pc<=target, next state KILL (the issued request is wrong-path).
  - WAIT, rvalid=0: stay. On redirect: pc<=target, next state KILL.
  - WAIT, rvalid=1 and redirect in the same cycle: discard data, pc<=target, next state ISSUE.
  - WAIT, rvalid=1, no redirect, slot free (stall_if_i=0 or valid_id_o=0): load IF/ID with {imem_rdata_i, pc, pc+4, valid=1}, pc<=pc+4, next state ISSUE.
  - WAIT, rvalid=1, no redirect, slot blocked (stall_if_i=1 and valid_id_o=1): capture data into the hold register, pc<=pc+4, next state HOLD.
  - HOLD, stall_if_i=0: move the hold register into IF/ID, next state ISSUE.
  - HOLD, redirect: drop the hold register, pc<=target, next state ISSUE.
  - KILL: on rvalid, discard and go to ISSUE. A redirect in KILL updates pc and stays in KILL (the latest target wins).
- IF/ID register priority, highest first:
  1. Redirect: valid_id_o<=0, instr_id_o<=NOP_INSTR. Flush beats stall.
  2. Stall with valid_id_o=1: hold all fields.
  3. New instruction from WAIT or HOLD: load it.
  4. Otherwise: valid_id_o<=0, instr_id_o<=NOP_INSTR; pc fields keep their value.
- pc+4 wraps modulo 2^32: 32'hFFFF_FFFC gives 0.
- Throughput: with 1-cycle memory latency, one instruction every 2 cycles (ISSUE, WAIT).
- Redirect-to-fetch latency:
  - Redirect in WAIT with no rvalid: the target request issues 2 cycles after the redirect, at the earliest (KILL, then ISSUE).
  - Redirect in WAIT with rvalid in the same cycle: the target request issues the next cycle.
- pc_if_o = pc register.

Test Plan:
- Reset release, 1-cycle-latency memory returning addr-tagged words: requests at 0x0, 0x4, 0x8 on alternating cycles. ID shows pc_id_o=0x0/0x4/0x8 with pc_order_id_o=0x4/0x8/0xC and valid_id_o=1. Reset values verified first.
- jump_taken_if_i=1, pc_new_if_i=0x100 while in WAIT with the response delayed 3 cycles: the late response is discarded. The next imem_addr_o is 0x100, and valid_id_o=0 the cycle after the redirect.
- Redirect coincident with rvalid (target 0x203, misaligned): data dropped, next request the following cycle to 0x200.
- stall_if_i=1 with valid_id_o=1 when rvalid returns instr 0xDEADBEEF: IF/ID is unchanged and no new request is issued. Release the stall: instr_id_o=0xDEADBEEF next cycle, then fetch resumes at pc+4.
- Stall and redirect asserted together in HOLD: valid_id_o=0, hold data lost, next request to the target.
- Fetch at 0xFFFF_FFFC: pc_order_id_o=0x0 and the next request is to 0x0. Reset asserted in WAIT then released: the stale rvalid is ignored and the first request is to RESET_PC.

Source files
------------

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage with IF/ID pipeline register.
// One imem request outstanding at a time; EX redirects flush IF/ID and retarget the PC.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        jump_taken_if_i,
    input  logic [31:0] pc_new_if_i,
    input  logic        stall_if_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic [31:0] imem_rdata_i,
    input  logic        imem_rvalid_i,
    output logic [31:0] instr_id_o,
    output logic [31:0] pc_id_o,
    output logic [31:0] pc_order_id_o,
    output logic        valid_id_o,
    output logic [31:0] pc_if_o
);

    typedef enum logic [1:0] {StIssue, StWait, StHold, StKill} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pc_plus4;
    logic [31:0] target;

    logic [31:0] instr_q, instr_d;
    logic [31:0] pc_id_q, pc_id_d;
    logic [31:0] pc_order_q, pc_order_d;
    logic        valid_q, valid_d;

    logic [31:0] hold_instr_q, hold_instr_d;
    logic [31:0] hold_pc_q, hold_pc_d;
    logic [31:0] hold_order_q, hold_order_d;

    logic        load_new;
    logic [31:0] new_instr;
    logic [31:0] new_pc;
    logic [31:0] new_order;

    assign pc_plus4 = pc_q + 32'd4;
    assign target   = pc_new_if_i & ~32'h3;

    // Fetch FSM and PC update.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        hold_instr_d = hold_instr_q;
        hold_pc_d    = hold_pc_q;
        hold_order_d = hold_order_q;
        load_new     = 1'b0;
        new_instr    = NOP_INSTR;
        new_pc       = pc_q;
        new_order    = pc_plus4;

        case (state_q)
            StIssue: begin
                if (jump_taken_if_i) begin
                    pc_d    = target;
                    state_d = StKill;
                end else begin
                    state_d = StWait;
                end
            end
            StWait: begin
                if (jump_taken_if_i) begin
                    pc_d    = target;
                    // A response arriving now settles the outstanding request.
                    state_d = imem_rvalid_i ? StIssue : StKill;
                end else if (imem_rvalid_i) begin
                    pc_d = pc_plus4;
                    if (!stall_if_i || !valid_q) begin
                        load_new  = 1'b1;
                        new_instr = imem_rdata_i;
                        new_pc    = pc_q;
                        new_order = pc_plus4;
                        state_d   = StIssue;
                    end else begin
                        hold_instr_d = imem_rdata_i;
                        hold_pc_d    = pc_q;
                        hold_order_d = pc_plus4;
                        state_d      = StHold;
                    end
                end
            end
            StHold: begin
                if (jump_taken_if_i) begin
                    pc_d    = target;
                    state_d = StIssue;
                end else if (!stall_if_i) begin
                    load_new  = 1'b1;
                    new_instr = hold_instr_q;
                    new_pc    = hold_pc_q;
                    new_order = hold_order_q;
                    state_d   = StIssue;
                end
            end
            StKill: begin
                if (jump_taken_if_i) begin
                    pc_d = target;
                end
                if (imem_rvalid_i) begin
                    state_d = StIssue;
                end
            end
            default: state_d = StIssue;
        endcase
    end

    // IF/ID register: flush beats stall beats new instruction.
    always_comb begin
        instr_d    = instr_q;
        pc_id_d    = pc_id_q;
        pc_order_d = pc_order_q;
        valid_d    = valid_q;

        if (jump_taken_if_i) begin
            valid_d = 1'b0;
            instr_d = NOP_INSTR;
        end else if (stall_if_i && valid_q) begin
            valid_d = 1'b1;
        end else if (load_new) begin
            valid_d    = 1'b1;
            instr_d    = new_instr;
            pc_id_d    = new_pc;
            pc_order_d = new_order;
        end else begin
            valid_d = 1'b0;
            instr_d = NOP_INSTR;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= StIssue;
            pc_q         <= RESET_PC;
            instr_q      <= NOP_INSTR;
            pc_id_q      <= 32'h0;
            pc_order_q   <= 32'h0;
            valid_q      <= 1'b0;
            hold_instr_q <= 32'h0;
            hold_pc_q    <= 32'h0;
            hold_order_q <= 32'h0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            instr_q      <= instr_d;
            pc_id_q      <= pc_id_d;
            pc_order_q   <= pc_order_d;
            valid_q      <= valid_d;
            hold_instr_q <= hold_instr_d;
            hold_pc_q    <= hold_pc_d;
            hold_order_q <= hold_order_d;
        end
    end

    // Request is suppressed while reset is held so nothing issues before release.
    assign imem_req_o    = rst_n && (state_q == StIssue);
    assign imem_addr_o   = pc_q;
    assign instr_id_o    = instr_q;
    assign pc_id_o       = pc_id_q;
    assign pc_order_id_o = pc_order_q;
    assign valid_id_o    = valid_q;
    assign pc_if_o       = pc_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed table-driven bench for if_fetch_stage; each row gives the inputs for one cycle
// and the outputs expected during that cycle (before the edge that consumes the inputs).
module tb_if_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst_n;
    logic        jump_taken_if_i;
    logic [31:0] pc_new_if_i;
    logic        stall_if_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic [31:0] imem_rdata_i;
    logic        imem_rvalid_i;
    logic [31:0] instr_id_o;
    logic [31:0] pc_id_o;
    logic [31:0] pc_order_id_o;
    logic        valid_id_o;
    logic [31:0] pc_if_o;

    int n_cmp;
    int n_fail;

    typedef struct {
        logic        rst;
        logic        jmp;
        logic [31:0] tgt;
        logic        stall;
        logic        rv;
        logic [31:0] rd;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_instr;
        logic [31:0] e_pc;
        logic [31:0] e_pc4;
        logic [31:0] e_pcif;
    } vec_t;

    vec_t vq[$];

    if_fetch_stage #(
        .RESET_PC (32'h0000_0000),
        .NOP_INSTR(NOP)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .jump_taken_if_i(jump_taken_if_i),
        .pc_new_if_i    (pc_new_if_i),
        .stall_if_i     (stall_if_i),
        .imem_req_o     (imem_req_o),
        .imem_addr_o    (imem_addr_o),
        .imem_rdata_i   (imem_rdata_i),
        .imem_rvalid_i  (imem_rvalid_i),
        .instr_id_o     (instr_id_o),
        .pc_id_o        (pc_id_o),
        .pc_order_id_o  (pc_order_id_o),
        .valid_id_o     (valid_id_o),
        .pc_if_o        (pc_if_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic add(input logic r, input logic j, input logic [31:0] t, input logic s,
                       input logic rv, input logic [31:0] rd, input logic er,
                       input logic [31:0] ea, input logic ev, input logic [31:0] ei,
                       input logic [31:0] ep, input logic [31:0] e4, input logic [31:0] ec);
        vec_t v;
        v.rst = r; v.jmp = j; v.tgt = t; v.stall = s; v.rv = rv; v.rd = rd;
        v.e_req = er; v.e_addr = ea; v.e_valid = ev; v.e_instr = ei;
        v.e_pc = ep; v.e_pc4 = e4; v.e_pcif = ec;
        vq.push_back(v);
    endtask

    task automatic drive(input logic r, input logic j, input logic [31:0] t, input logic s,
                         input logic rv, input logic [31:0] rd);
        @(negedge clk);
        rst_n           = r;
        jump_taken_if_i = j;
        pc_new_if_i     = t;
        stall_if_i      = s;
        imem_rvalid_i   = rv;
        imem_rdata_i    = rd;
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    initial begin
        bit ok;
        bit found;
        int hit;
        n_cmp  = 0;
        n_fail = 0;
        rst_n           = 1'b0;
        jump_taken_if_i = 1'b0;
        pc_new_if_i     = 32'h0;
        stall_if_i      = 1'b0;
        imem_rvalid_i   = 1'b0;
        imem_rdata_i    = 32'h0;

        // Reset, then straight-line fetch of 0x0/0x4/0x8 with 1-cycle memory.
        add(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0,
            1'b0, 32'h0, 1'b0, NOP, 32'h0, 32'h0, 32'h0);
        add(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0,
            1'b1, 32'h0, 1'b0, NOP, 32'h0, 32'h0, 32'h0);
        add(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'hC000_0000,
            1'b0, 32'h0, 1'b0, NOP, 32'h0, 32'h0, 32'h0);
        add(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0,
            1'b1, 32'h4, 1'b1, 32'hC000_0000, 32'h0, 32'h4, 32'h4);
        add(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'hC000_0004,
            1'b0, 32'h0, 1'b0, NOP, 32'h0, 32'h4, 32'h4);
        add(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0,
            1'b1, 32'h8, 1'b1, 32'hC000_0004, 32'h4, 32'h8, 32'h8);
        add(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'hC000_0008,
            1'b0, 32'h0, 1'b0, NOP, 32'h4, 32'h8, 32'h8);
        add(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0,
            1'b1, 32'hC, 1'b1, 32'hC000_0008, 32'h8, 32'hC, 32'hC);
        // Redirect to 0x100 in WAIT; the response for 0xC arrives 3 cycles late.
        add(1'b1, 1'b1, 32'h100, 1'b0, 1'b0, 32'h0,
            1'b0, 32'h0, 1'b0, NOP, 32'h8, 32'hC, 32'hC);
        add(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0,
            1'b0, 32'h0, 1'b0, NOP, 32'h8, 32'hC, 32'h100);
        add(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'hC000_000C,
            1'b0, 32'h0, 1'b0, NOP, 32'h8, 32'hC, 32'h100);
        add(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0,
            1'b1, 32'h100, 1'b0, NOP, 32'h8, 32'hC, 32'h100);
        // Redirect to misaligned 0x203 coincident with rvalid.
        add(1'b1, 1'b1, 32'h203, 1'b0, 1'b1, 32'hC000_0100,
            1'b0, 32'h0, 1'b0, NOP, 32'h8, 32'hC, 32'h100);
        add(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0,
            1'b1, 32'h200, 1'b0, NOP, 32'h8, 32'hC, 32'h200);
        add(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'hC000_0200,
            1'b0, 32'h0, 1'b0, NOP, 32'h8, 32'hC, 32'h200);
        // Stall while 0xDEADBEEF returns: captured in HOLD, released later.
        add(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0,
            1'b1, 32'h204, 1'b1, 32'hC000_0200, 32'h200, 32'h204, 32'h204);
        add(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'hDEAD_BEEF,
            1'b0, 32'h0, 1'b1, 32'hC000_0200, 32'h200, 32'h204, 32'h204);
        add(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0,
            1'b0, 32'h0, 1'b1, 32'hC000_0200, 32'h200, 32'h204, 32'h208);
        add(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'h1234_5678,
            1'b0, 32'h0, 1'b1, 32'hC000_0200, 32'h200, 32'h204, 32'h208);
        add(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0,
            1'b0, 32'h0, 1'b1, 32'hC000_0200, 32'h200, 32'h204, 32'h208);
        add(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0,
            1'b1, 32'h208, 1'b1, 32'hDEAD_BEEF, 32'h204, 32'h208, 32'h208);
        add(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'hC000_0208,
            1'b0, 32'h0, 1'b0, NOP, 32'h204, 32'h208, 32'h208);
        // Into HOLD again, then stall and redirect together.
        add(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0,
            1'b1, 32'h20C, 1'b1, 32'hC000_0208, 32'h208, 32'h20C, 32'h20C);
        add(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'hC000_020C,
            1'b0, 32'h0, 1'b1, 32'hC000_0208, 32'h208, 32'h20C, 32'h20C);
        add(1'b1, 1'b1, 32'hFFFF_FFFC, 1'b1, 1'b0, 32'h0,
            1'b0, 32'h0, 1'b1, 32'hC000_0208, 32'h208, 32'h20C, 32'h210);
        // Fetch at the top of the address space: pc+4 wraps to 0.
        add(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0,
            1'b1, 32'hFFFF_FFFC, 1'b0, NOP, 32'h208, 32'h20C, 32'hFFFF_FFFC);
        add(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'hFFFF_FFFC,
            1'b0, 32'h0, 1'b0, NOP, 32'h208, 32'h20C, 32'hFFFF_FFFC);
        add(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0,
            1'b1, 32'h0, 1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0, 32'h0);
        add(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'hC000_0000,
            1'b0, 32'h0, 1'b0, NOP, 32'hFFFF_FFFC, 32'h0, 32'h0);
        add(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0,
            1'b1, 32'h4, 1'b1, 32'hC000_0000, 32'h0, 32'h4, 32'h4);
        // Reset in WAIT with a stale response straddling the release.
        add(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hC000_0004,
            1'b0, 32'h0, 1'b0, NOP, 32'h0, 32'h4, 32'h4);
        add(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'hC000_0004,
            1'b1, 32'h0, 1'b0, NOP, 32'h0, 32'h0, 32'h0);
        add(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'hC000_0000,
            1'b0, 32'h0, 1'b0, NOP, 32'h0, 32'h0, 32'h0);
        add(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0,
            1'b1, 32'h4, 1'b1, 32'hC000_0000, 32'h0, 32'h4, 32'h4);

        foreach (vq[i]) begin
            drive(vq[i].rst, vq[i].jmp, vq[i].tgt, vq[i].stall, vq[i].rv, vq[i].rd);
            ok = (imem_req_o === vq[i].e_req) &&
                 (!vq[i].e_req || imem_addr_o === vq[i].e_addr) &&
                 (valid_id_o === vq[i].e_valid) && (instr_id_o === vq[i].e_instr) &&
                 (pc_id_o === vq[i].e_pc) && (pc_order_id_o === vq[i].e_pc4) &&
                 (pc_if_o === vq[i].e_pcif);
            n_cmp++;
            if (!ok) begin
                n_fail++;
                $display("FAIL vec%0d: got req=%b addr=%h v=%b ins=%h pc=%h pc4=%h pcif=%h",
                         i, imem_req_o, imem_addr_o, valid_id_o, instr_id_o, pc_id_o,
                         pc_order_id_o, pc_if_o);
                $display("     vec%0d required req=%b addr=%h v=%b ins=%h pc=%h pc4=%h pcif=%h",
                         i, vq[i].e_req, vq[i].e_addr, vq[i].e_valid, vq[i].e_instr,
                         vq[i].e_pc, vq[i].e_pc4, vq[i].e_pcif);
            end
        end

        // Redirect during ISSUE: the issued request is wrong-path and must be drained.
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'hC000_0004);
        drive(1'b1, 1'b1, 32'h400, 1'b0, 1'b0, 32'h0);
        check("issue_req", {31'h0, imem_req_o}, 32'h1);
        check("issue_addr", imem_addr_o, 32'h8);
        found = 1'b0;
        hit   = -1;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b0, 32'h0, 1'b0, (i == 0), 32'h0000_0BAD);
            if (i == 0) check("kill_flush_valid", {31'h0, valid_id_o}, 32'h0);
            if (imem_req_o) begin
                found = 1'b1;
                hit   = i;
                break;
            end
        end
        check("kill_req_seen", {31'h0, found}, 32'h1);
        check("kill_req_cycle", hit, 32'd1);
        check("kill_req_addr", imem_addr_o, 32'h400);
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'hC000_0400);
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        check("tgt_valid", {31'h0, valid_id_o}, 32'h1);
        check("tgt_instr", instr_id_o, 32'hC000_0400);
        check("tgt_pc", pc_id_o, 32'h400);
        check("tgt_pc4", pc_order_id_o, 32'h404);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
